// File: rtl/raid_pkg.sv
// Shared types and constants for the RAID read/write sequencing blocks.
package raid_pkg;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_ISSUE    = 2'd1,
        RD_WAIT_MEM = 2'd2,
        RD_WAIT_WR  = 2'd3
    } rd_state_e;

    localparam int RAID_DATA_W = 12;
    localparam int RAID_ADDR_W = 8;

    // Callers zero-extend their mask to 32 bits.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/raid_rd_timer.sv
// Clearable saturating cycle counter; expired is high once the count sits at TIMEOUT.
module raid_rd_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/raid_read_sequencer.sv
// Read-side stripe sequencer: reads NUM_STRIPES stripes from all healthy disks,
// handing each stripe to the write side and waiting for write_done in between.
//
// state    | meaning
// IDLE     | waiting for enable, outputs parked at 0
// ISSUE    | rd_en driven for one cycle at the current stripe address
// WAIT_MEM | waiting for mem_valid, timer running
// WAIT_WR  | stripe handed over, waiting for write_done
module raid_read_sequencer
    import raid_pkg::*;
#(
    parameter int NUM_DISKS   = 3,
    parameter int DATA_W      = RAID_DATA_W,
    parameter int ADDR_W      = RAID_ADDR_W,
    parameter int NUM_STRIPES = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_DISKS-1:0]        disk_stat,
    input  logic                        mem_valid,
    input  logic [NUM_DISKS*DATA_W-1:0] in_rd_data,
    input  logic                        write_done,
    output logic [NUM_DISKS-1:0]        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    output logic [NUM_DISKS*DATA_W-1:0] rd_data,
    output logic                        data_valid,
    output logic                        last_op,
    output logic [NUM_DISKS-1:0]        disk_stat_out,
    output logic                        busy,
    output logic                        err_degraded,
    output logic                        err_timeout
);

    localparam logic [1:0] IDLE     = RD_IDLE;
    localparam logic [1:0] ISSUE    = RD_ISSUE;
    localparam logic [1:0] WAIT_MEM = RD_WAIT_MEM;
    localparam logic [1:0] WAIT_WR  = RD_WAIT_WR;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_STRIPES - 1);

    logic [1:0]                  state;
    logic [NUM_DISKS*DATA_W-1:0] lane_mask;
    logic                        healthy_ok;
    logic                        timer_expired;

    // A single failed disk is recoverable through the Hamming code; two are not.
    assign healthy_ok = popcount(32'(disk_stat)) >= 32'(NUM_DISKS - 1);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_DISKS; i++) begin
            lane_mask[i*DATA_W +: DATA_W] = {DATA_W{disk_stat_out[i]}};
        end
    end

    raid_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ISSUE),
        .count_en ((state == WAIT_MEM) && !mem_valid),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rd_en         <= '0;
            rd_addr       <= '0;
            rd_data       <= '0;
            data_valid    <= 1'b0;
            last_op       <= 1'b0;
            disk_stat_out <= '0;
            busy          <= 1'b0;
            err_degraded  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            rd_en        <= '0;
            data_valid   <= 1'b0;
            last_op      <= 1'b0;
            err_degraded <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (healthy_ok) begin
                            state         <= ISSUE;
                            busy          <= 1'b1;
                            disk_stat_out <= disk_stat;
                            rd_addr       <= '0;
                            rd_en         <= disk_stat;
                        end else begin
                            err_degraded <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    // Data arriving in the expiry cycle still wins over the abort.
                    if (mem_valid) begin
                        state      <= WAIT_WR;
                        rd_data    <= in_rd_data & lane_mask;
                        data_valid <= 1'b1;
                        last_op    <= (rd_addr == LAST_ADDR);
                    end else if (timer_expired) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        rd_addr       <= '0;
                        rd_data       <= '0;
                        disk_stat_out <= '0;
                        err_timeout   <= 1'b1;
                    end
                end
                WAIT_WR: begin
                    if (write_done) begin
                        if (rd_addr == LAST_ADDR) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            rd_addr       <= '0;
                            rd_data       <= '0;
                            disk_stat_out <= '0;
                        end else begin
                            state   <= ISSUE;
                            rd_addr <= rd_addr + 1'b1;
                            rd_en   <= disk_stat_out;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    rd_addr       <= '0;
                    rd_data       <= '0;
                    disk_stat_out <= '0;
                end
            endcase
        end
    end

endmodule
